// File: rtl/video_prefetch.sv
// Scanline prefetcher: streams a frame from SDRAM into a show-ahead pixel FIFO.
// Optional sticky underflow flag is enabled with `define VIDEO_PREFETCH_UNDERFLOW_EN.
module video_prefetch #(
    parameter int unsigned WORDS_PER_LINE = 160,
    parameter int unsigned LINES          = 480,
    parameter int unsigned FIFO_DEPTH     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frameStart,
    input  logic [20:0] frameBase,
    output logic        videoChipEnable,
    output logic        videoRead,
    output logic [20:0] videoAddress,
    input  logic        videoWaitRequest,
    input  logic        videoReadValid,
    input  logic [31:0] videoDataIn,
    input  logic        pixelReq,
    output logic [31:0] pixelData,
    output logic        pixelValid,
    output logic        underflow
);

    localparam int unsigned TOTAL = WORDS_PER_LINE * LINES;
    localparam int unsigned IW    = $clog2(TOTAL + 1);
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH, DONE} state_t;

    state_t          r_state;
    logic [20:0]     r_base;
    logic [IW-1:0]   r_issued;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic            r_read;
    logic [20:0]     r_addr;
    logic [31:0]     r_mem [FIFO_DEPTH];

    logic            w_acc;
    logic            w_ret;
    logic            w_push;
    logic            w_pop;
    logic            w_hold;
    logic            w_room;
    logic [CW-1:0]   w_out_n;
    logic [CW-1:0]   w_cnt_n;
    logic [IW-1:0]   w_iss_n;
    logic [CW:0]     w_reserved;
    logic [20:0]     w_next_addr;

    assign w_acc       = r_read & ~videoWaitRequest;
    assign w_hold      = r_read & videoWaitRequest;
    // Returns are only meaningful while reads are in flight; anything else is stale.
    assign w_ret       = videoReadValid & (r_outstanding != '0) & (r_state != IDLE);
    assign w_push      = w_ret & ((r_state == FETCH) | (r_state == DONE));
    assign w_pop       = pixelReq & (r_count != '0);
    assign w_out_n     = r_outstanding + CW'(w_acc) - CW'(w_ret);
    assign w_cnt_n     = r_count + CW'(w_push) - CW'(w_pop);
    assign w_iss_n     = r_issued + IW'(w_acc);
    // FIFO slots already claimed by stored words plus reads in flight.
    assign w_reserved  = {1'b0, w_cnt_n} + {1'b0, w_out_n};
    assign w_room      = w_reserved < DEPTH_L;
    assign w_next_addr = r_base + 21'(w_iss_n);

    assign videoRead       = r_read;
    assign videoChipEnable = r_read;
    assign videoAddress    = r_addr;
    assign pixelValid      = (r_count != '0);
    assign pixelData       = (r_count != '0) ? r_mem[r_rptr] : 32'h0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= videoDataIn;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_base        <= '0;
            r_issued      <= '0;
            r_outstanding <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_read        <= 1'b0;
            r_addr        <= '0;
        end else begin
            r_outstanding <= w_out_n;
            r_issued      <= w_iss_n;
            r_count       <= w_cnt_n;
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);

            unique case (r_state)
                IDLE: begin
                    r_read <= 1'b0;
                    if (frameStart) begin
                        r_base   <= frameBase;
                        r_issued <= '0;
                        r_count  <= '0;
                        r_wptr   <= '0;
                        r_rptr   <= '0;
                        r_state  <= FETCH;
                    end
                end
                FETCH: begin
                    if (frameStart) begin
                        r_base   <= frameBase;
                        r_issued <= '0;
                        r_count  <= '0;
                        r_wptr   <= '0;
                        r_rptr   <= '0;
                        r_read   <= w_hold;
                        r_state  <= ((w_out_n != '0) || w_hold) ? FLUSH : FETCH;
                    end else if (!w_hold) begin
                        if (w_iss_n == IW'(TOTAL)) begin
                            r_read  <= 1'b0;
                            r_state <= DONE;
                        end else if (w_room) begin
                            r_read <= 1'b1;
                            r_addr <= w_next_addr;
                        end else begin
                            r_read <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (w_acc) r_read <= 1'b0;
                    if (frameStart) begin
                        r_base <= frameBase;
                    end else if ((w_out_n == '0) && !r_read) begin
                        r_issued <= '0;
                        r_count  <= '0;
                        r_wptr   <= '0;
                        r_rptr   <= '0;
                        r_state  <= FETCH;
                    end
                end
                DONE: begin
                    r_read <= 1'b0;
                    if (frameStart) begin
                        r_base   <= frameBase;
                        r_issued <= '0;
                        r_count  <= '0;
                        r_wptr   <= '0;
                        r_rptr   <= '0;
                        r_state  <= (w_out_n != '0) ? FLUSH : FETCH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef VIDEO_PREFETCH_UNDERFLOW_EN
    logic r_underflow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_underflow <= 1'b0;
        end else if (frameStart) begin
            r_underflow <= 1'b0;
        end else if (pixelReq && (r_count == '0)) begin
            r_underflow <= 1'b1;
        end
    end

    assign underflow = r_underflow;
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_video_prefetch.sv
// Scoreboard bench for video_prefetch: SDRAM responder model, frame-level pixel model.
module tb_video_prefetch;

    localparam int unsigned WPL   = 16;
    localparam int unsigned LNS   = 20;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned TOTAL = WPL * LNS;
`ifdef VIDEO_PREFETCH_UNDERFLOW_EN
    localparam logic UF_EXP = 1'b1;
`else
    localparam logic UF_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frameStart = 1'b0;
    logic [20:0] frameBase = '0;
    logic        videoChipEnable;
    logic        videoRead;
    logic [20:0] videoAddress;
    logic        videoWaitRequest;
    logic        videoReadValid;
    logic [31:0] videoDataIn;
    logic        pixelReq;
    logic [31:0] pixelData;
    logic        pixelValid;
    logic        underflow;

    video_prefetch #(
        .WORDS_PER_LINE(WPL),
        .LINES(LNS),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frameStart(frameStart),
        .frameBase(frameBase),
        .videoChipEnable(videoChipEnable),
        .videoRead(videoRead),
        .videoAddress(videoAddress),
        .videoWaitRequest(videoWaitRequest),
        .videoReadValid(videoReadValid),
        .videoDataIn(videoDataIn),
        .pixelReq(pixelReq),
        .pixelData(pixelData),
        .pixelValid(pixelValid),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [20:0] a);
        return {a[10:0] ^ 11'h5a3, a};
    endfunction

    typedef struct {
        logic [20:0] addr;
        int          due;
    } ret_t;

    ret_t        ret_q[$];
    logic [20:0] acc_addrs[$];
    logic [31:0] exp_q[$];
    int          cyc = 0;
    int          last_due = 0;
    int          acc_count = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          wait_rand = 1'b0;
    bit          wait_hi = 1'b0;
    int          pix_mode = 0;
    logic        ufl_model = 1'b0;

    // SDRAM responder: drives wait/returns just after each rising edge.
    initial begin
        videoWaitRequest = 1'b0;
        videoReadValid   = 1'b0;
        videoDataIn      = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            videoReadValid = 1'b0;
            if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                videoReadValid = 1'b1;
                videoDataIn    = mem_word(ret_q[0].addr);
                void'(ret_q.pop_front());
            end
            videoWaitRequest = wait_hi ? 1'b1 :
                               (wait_rand ? ($urandom_range(0, 3) == 0) : 1'b0);
        end
    end

    // Acceptance monitor: the next edge accepts what is presented now.
    initial begin : acc_mon
        ret_t r;
        int   d;
        forever begin
            @(negedge clk);
            if (reset && videoRead && !videoWaitRequest) begin
                d = cyc + int'($urandom_range(lat_max, lat_min));
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                r.addr = videoAddress;
                r.due  = d;
                ret_q.push_back(r);
                acc_count++;
                acc_addrs.push_back(videoAddress);
            end
        end
    end

    initial begin
        pixelReq = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pixelReq = (pix_mode == 1) ? 1'b1 :
                       (pix_mode == 2) ? 1'(($urandom_range(0, 1))) : 1'b0;
        end
    end

    // Pixel monitor: pops compared against the frame's expected word sequence.
    initial begin : pix_mon
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
                ufl_model = 1'b0;
            end else if (pixelReq && pixelValid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop actual=0x%0h required=no_word", pixelData);
                end else begin
                    check("pixel_data", pixelData, exp_q.pop_front());
                end
            end
            check("underflow", 32'(underflow), 32'(ufl_model));
            if (reset) begin
                if (frameStart) begin
                    ufl_model = 1'b0;
                    exp_q.delete();
                    for (int i = 0; i < int'(TOTAL); i++) begin
                        exp_q.push_back(mem_word(frameBase + 21'(i)));
                    end
                end
`ifdef VIDEO_PREFETCH_UNDERFLOW_EN
                else if (pixelReq && !pixelValid) begin
                    ufl_model = 1'b1;
                end
`endif
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        frameStart = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        acc_count = 0;
        acc_addrs.delete();
    endtask

    task automatic start_frame(input logic [20:0] b);
        @(posedge clk);
        #1;
        frameBase  = b;
        frameStart = 1'b1;
        @(posedge clk);
        #1;
        frameStart = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && !pixelValid) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 4000) begin
            failures++;
            $display("FAIL %s drain_timeout remaining=%0d required=0", name, exp_q.size());
        end
    endtask

    task automatic wait_acc(input int target, input string name);
        int n = 0;
        while (acc_count < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL %s accept_timeout actual=%0d required=%0d", name, acc_count, target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check("rst_read", 32'(videoRead), 32'h0);
        check("rst_ce", 32'(videoChipEnable), 32'h0);
        check("rst_addr", 32'(videoAddress), 32'h0);
        check("rst_valid", 32'(pixelValid), 32'h0);
        check("rst_data", pixelData, 32'h0);
        check("rst_underflow", 32'(underflow), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Full frame, zero wait, 1-cycle latency, continuous pops.
        lat_min = 1; lat_max = 1; wait_rand = 1'b0; wait_hi = 1'b0; pix_mode = 1;
        start_frame(21'h1000);
        wait_drain("s1");
        repeat (5) @(negedge clk);
        check("s1_read_idle", 32'(videoRead), 32'h0);
        check("s1_acc_count", acc_count, TOTAL);
        check("s1_first_addr", 32'(acc_addrs[0]), 32'h1000);
        check("s1_last_addr", 32'(acc_addrs[TOTAL-1]), 32'h1000 + TOTAL - 1);

        // Fill without pops; addresses wrap at 2^21.
        do_reset();
        lat_min = 1; lat_max = 4; wait_rand = 1'b1; pix_mode = 0;
        start_frame(21'h1FFFF0);
        repeat (400) @(negedge clk);
        check("s2_acc_count", acc_count, DEPTH);
        check("s2_read_stop", 32'(videoRead), 32'h0);
        check("s2_valid", 32'(pixelValid), 32'h1);
        check("s2_head", pixelData, mem_word(21'h1FFFF0));
        check("s2_wrap_hi", 32'(acc_addrs[15]), 32'h1FFFFF);
        check("s2_wrap_lo", 32'(acc_addrs[16]), 32'h0);
        pix_mode = 2;
        wait_drain("s2");
        check("s2_total", acc_count, TOTAL);

        // First request stalled for 5 cycles.
        do_reset();
        wait_rand = 1'b0; wait_hi = 1'b1; pix_mode = 0;
        start_frame(21'h2000);
        n = 0;
        @(negedge clk);
        while (!videoRead && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("s3_hold_read", 32'(videoRead), 32'h1);
            check("s3_hold_addr", 32'(videoAddress), 32'h2000);
            if (k < 4) @(negedge clk);
        end
        check("s3_no_accept", acc_count, 0);
        wait_hi = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("s3_one_accept", acc_count, 1);
        check("s3_next_addr", 32'(videoAddress), 32'h2001);
        pix_mode = 2; wait_rand = 1'b1;
        wait_drain("s3");

        // Restart with 10 reads in flight and one held.
        do_reset();
        lat_min = 20; lat_max = 20; wait_rand = 1'b0; wait_hi = 1'b0; pix_mode = 0;
        start_frame(21'h3000);
        wait_acc(10, "s4_fill");
        wait_hi = 1'b1;
        start_frame(21'h5000);
        repeat (2) @(negedge clk);
        wait_hi = 1'b0;
        n = 0;
        while (ret_q.size() != 0 && n < 200) begin
            @(negedge clk);
            check("s4_flush_valid", 32'(pixelValid), 32'h0);
            n++;
        end
        check("s4_flushed_reads", acc_count, 11);
        check("s4_held_addr", 32'(acc_addrs[10]), 32'h300A);
        acc_addrs.delete();
        lat_min = 1; lat_max = 4;
        n = 0;
        while (acc_addrs.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("s4_restart_addr", 32'(acc_addrs[0]), 32'h5000);
        pix_mode = 2; wait_rand = 1'b1;
        wait_drain("s4");

        // Pop while empty.
        do_reset();
        wait_rand = 1'b0; pix_mode = 1;
        repeat (5) @(negedge clk);
        check("s5_underflow_set", 32'(underflow), 32'(UF_EXP));
        pix_mode = 0;
        repeat (3) @(negedge clk);
        check("s5_underflow_sticky", 32'(underflow), 32'(UF_EXP));
        start_frame(21'h0);
        @(negedge clk);
        check("s5_underflow_clear", 32'(underflow), 32'h0);
        pix_mode = 2;
        wait_drain("s5");

        // Reset mid-fetch with late returns.
        do_reset();
        lat_min = 10; lat_max = 10; wait_rand = 1'b0; wait_hi = 1'b0; pix_mode = 0;
        start_frame(21'h100);
        wait_acc(3, "s6_fill");
        wait_hi = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_hi = 1'b0;
        acc_count = 0;
        check("s6_late_pending", ret_q.size(), 3);
        n = 0;
        while (ret_q.size() != 0 && n < 100) begin
            @(negedge clk);
            check("s6_valid_idle", 32'(pixelValid), 32'h0);
            n++;
        end
        repeat (3) @(negedge clk);
        check("s6_valid_end", 32'(pixelValid), 32'h0);
        check("s6_read_end", 32'(videoRead), 32'h0);
        check("s6_no_reads", acc_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
